// File: rtl/note_envelope_adsr_if.sv
// ---------------------------------------------------------------------------
// note_envelope_adsr_if
// Bundles the gate, sample and envelope-shape inputs together with the
// enveloped outputs of note_envelope_adsr.
//   master : drives noteOn, inputSample, attackStep, decayStep, sustainLevel,
//            releaseStep; observes outputSample, envelopeLevel,
//            envelopeState, busy
//   slave  : the envelope stage itself (the reverse directions)
// Parameter STATE_W sets the width of envelopeState.
// ---------------------------------------------------------------------------
interface note_envelope_adsr_if #(
    parameter int STATE_W = 3
);
    logic               noteOn;
    logic [7:0]         inputSample;
    logic [7:0]         attackStep;
    logic [7:0]         decayStep;
    logic [7:0]         sustainLevel;
    logic [7:0]         releaseStep;
    logic [7:0]         outputSample;
    logic [7:0]         envelopeLevel;
    logic [STATE_W-1:0] envelopeState;
    logic               busy;

    modport master (
        output noteOn, inputSample, attackStep, decayStep, sustainLevel, releaseStep,
        input  outputSample, envelopeLevel, envelopeState, busy
    );

    modport slave (
        input  noteOn, inputSample, attackStep, decayStep, sustainLevel, releaseStep,
        output outputSample, envelopeLevel, envelopeState, busy
    );
endinterface

// File: rtl/note_envelope_adsr.sv
// ---------------------------------------------------------------------------
// note_envelope_adsr
// ADSR amplitude envelope for the 8-bit tone generators. The raw sample is
// scaled by the top byte of a 16-bit envelope accumulator so notes fade in
// and out instead of clicking. Output feeds the mixer / PWM DAC.
//
// Ports:
//   CLK_32KHz  in  sample-rate clock (one envelope tick per cycle)
//   reset_n    in  asynchronous, active-low reset
//   env        note_envelope_adsr_if.slave
//                noteOn        gate level, high = key held
//                inputSample   unsigned generator sample
//                attackStep / decayStep / releaseStep  per-tick acc steps
//                sustainLevel  sustain target, acc target = {sustainLevel,8'h00}
//                outputSample  enveloped sample, registered (1-cycle latency)
//                envelopeLevel acc[ACC_W-1 -: 8]
//                envelopeState IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//                busy          envelopeState != IDLE
//
// Build option: define ADSR_CENTERED_SCALE_EN to scale about mid-scale 128
// (idle/reset output 128) instead of toward 0 (idle/reset output 0).
// ---------------------------------------------------------------------------
module note_envelope_adsr #(
    parameter int ACC_W   = 16,
    parameter int STATE_W = 3
) (
    input  logic                 CLK_32KHz,
    input  logic                 reset_n,
    note_envelope_adsr_if.slave  env
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
`ifdef ADSR_CENTERED_SCALE_EN
    localparam logic [7:0] IDLE_OUT = 8'd128;
`else
    localparam logic [7:0] IDLE_OUT = 8'd0;
`endif

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             noteOn_q;
    logic [7:0]       out_reg;

    logic             rise;
    logic             fall;
    logic [7:0]       level;
    logic [ACC_W-1:0] target;
    logic [ACC_W:0]   attack_sum;
    logic [ACC_W:0]   decay_limit;
    logic [ACC_W-1:0] attack_next;
    logic [ACC_W-1:0] decay_next;
    logic [ACC_W-1:0] release_next;
    logic [7:0]       scaled_sample;

    assign rise   = env.noteOn & ~noteOn_q;
    assign fall   = ~env.noteOn & noteOn_q;
    assign level  = acc_reg[ACC_W-1 -: 8];
    assign target = {env.sustainLevel, {(ACC_W-8){1'b0}}};

    // Step arithmetic is done one bit wider so saturation/clamping can be
    // decided without wrap-around. A zero step means "jump to the limit".
    always_comb begin
        attack_sum  = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, env.attackStep};
        decay_limit = {1'b0, target} + {{(ACC_W-7){1'b0}}, env.decayStep};

        if (env.attackStep == 8'd0 || attack_sum[ACC_W])
            attack_next = ACC_MAX;
        else
            attack_next = attack_sum[ACC_W-1:0];

        // acc - step <= target  <=>  acc <= target + step; also covers an
        // acc already below a freshly raised target.
        if (env.decayStep == 8'd0 || {1'b0, acc_reg} <= decay_limit)
            decay_next = target;
        else
            decay_next = acc_reg - {{(ACC_W-8){1'b0}}, env.decayStep};

        if (env.releaseStep == 8'd0 || acc_reg <= {{(ACC_W-8){1'b0}}, env.releaseStep})
            release_next = '0;
        else
            release_next = acc_reg - {{(ACC_W-8){1'b0}}, env.releaseStep};
    end

    // Sample scaling by (L+1)/256 so that L=255 passes the sample through.
    // Operands are pre-widened so the product never truncates before the shift.
`ifdef ADSR_CENTERED_SCALE_EN
    logic signed [18:0] samp_s;
    logic signed [18:0] gain_s;
    always_comb begin
        samp_s        = $signed({11'b0, env.inputSample}) - 19'sd128;
        gain_s        = $signed({11'b0, level}) + 19'sd1;
        scaled_sample = 8'((samp_s * gain_s) >>> 8) + 8'd128;
    end
`else
    logic [15:0] samp_u;
    logic [15:0] gain_u;
    always_comb begin
        samp_u        = {8'h00, env.inputSample};
        gain_u        = {8'h00, level} + 16'd1;
        scaled_sample = 8'((samp_u * gain_u) >> 8);
    end
`endif

    // The current state's acc rule is applied on the same edge as any state
    // change; the new state's rule takes over from the following tick.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            noteOn_q  <= 1'b0;
            out_reg   <= IDLE_OUT;
        end else begin
            noteOn_q <= env.noteOn;
            // Output uses the level before this tick's update.
            out_reg  <= (state_reg == ST_IDLE) ? IDLE_OUT : scaled_sample;

            case (state_reg)
                ST_IDLE: begin
                    acc_reg <= '0;
                    if (rise) state_reg <= ST_ATTACK;
                end
                ST_ATTACK: begin
                    acc_reg <= attack_next;
                    if (fall)                        state_reg <= ST_RELEASE;
                    else if (attack_next == ACC_MAX) state_reg <= ST_DECAY;
                end
                ST_DECAY: begin
                    acc_reg <= decay_next;
                    if (fall)                      state_reg <= ST_RELEASE;
                    else if (decay_next == target) state_reg <= ST_SUSTAIN;
                end
                ST_SUSTAIN: begin
                    acc_reg <= target;
                    if (fall) state_reg <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    acc_reg <= release_next;
                    // A new key press resumes attack from the current level.
                    if (rise)                    state_reg <= ST_ATTACK;
                    else if (release_next == '0) state_reg <= ST_IDLE;
                end
                default: begin
                    acc_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign env.outputSample  = out_reg;
    assign env.envelopeLevel = level;
    assign env.envelopeState = STATE_W'(state_reg);
    assign env.busy          = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_note_envelope_adsr.sv
// ---------------------------------------------------------------------------
// tb_note_envelope_adsr
// Self-checking bench for note_envelope_adsr: timing of the ADSR phases,
// sample scaling through a scoreboard, zero-step jumps, retrigger from
// release, and asynchronous reset in the middle of a note.
// Honours ADSR_CENTERED_SCALE_EN for the expected output values.
// ---------------------------------------------------------------------------
module tb_note_envelope_adsr;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
`ifdef ADSR_CENTERED_SCALE_EN
    localparam logic [7:0] IDLE_OUT = 8'd128;
`else
    localparam logic [7:0] IDLE_OUT = 8'd0;
`endif

    logic CLK_32KHz = 1'b0;
    logic reset_n;

    note_envelope_adsr_if #(.STATE_W(3)) bus ();

    note_envelope_adsr #(.ACC_W(16), .STATE_W(3)) dut (
        .CLK_32KHz (CLK_32KHz),
        .reset_n   (reset_n),
        .env       (bus)
    );

    always #5 CLK_32KHz = ~CLK_32KHz;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] sample;
        logic [7:0] value;
    } exp_t;
    exp_t sb[$];

    // Reference scaling: out = (in*(L+1))>>8, or about 128 when centred.
    function automatic logic [7:0] model_out(input logic [7:0] smp, input logic [7:0] lvl);
        int g;
        g = int'(lvl) + 1;
`ifdef ADSR_CENTERED_SCALE_EN
        begin
            int s;
            s = int'(smp) - 128;
            return 8'(128 + ((s * g) >>> 8));
        end
`else
        return 8'((int'(smp) * g) >> 8);
`endif
    endfunction

    task automatic tick();
        @(posedge CLK_32KHz);
        #1;
    endtask

    task automatic wait_for_state(input logic [2:0] st, input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            tick();
            n++;
            if (bus.envelopeState === st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if (bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        total++; if (bus.envelopeLevel !== 8'h00) begin bad++; $display("FAIL reset_level got=%0h want=00", bus.envelopeLevel); end
        total++; if (bus.outputSample !== IDLE_OUT) begin bad++; $display("FAIL reset_out got=%0d want=%0d", bus.outputSample, IDLE_OUT); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        reset_n = 1'b1;
        bus.inputSample = 8'd200;
        tick();
        total++; if (bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL post_reset_state got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        total++; if (bus.outputSample !== IDLE_OUT) begin bad++; $display("FAIL post_reset_out got=%0d want=%0d", bus.outputSample, IDLE_OUT); end
        $display("reset: state=%0d level=%0h out=%0d busy=%b", bus.envelopeState, bus.envelopeLevel, bus.outputSample, bus.busy);
    endtask

    task automatic test_full_adsr();
        int  n;
        bit  ok;
        exp_t e;
        logic [7:0] v;
        bus.attackStep   = 8'd255;
        bus.decayStep    = 8'd128;
        bus.sustainLevel = 8'h80;
        bus.releaseStep  = 8'd64;
        bus.noteOn       = 1'b1;
        // One tick to see the edge, then 257 steps of 255 to reach FFFF.
        wait_for_state(S_DECAY, 1000, n, ok);
        total++; if (!ok || n != 258) begin bad++; $display("FAIL attack_len got=%0d want=258 (reached=%0b)", n, ok); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL attack_busy got=%b want=1", bus.busy); end
        total++; if (bus.envelopeLevel !== 8'hFF) begin bad++; $display("FAIL attack_peak got=%0h want=ff", bus.envelopeLevel); end
        wait_for_state(S_SUSTAIN, 1000, n, ok);
        total++; if (!ok || n != 256) begin bad++; $display("FAIL decay_len got=%0d want=256 (reached=%0b)", n, ok); end
        total++; if (bus.envelopeLevel !== 8'h80) begin bad++; $display("FAIL sustain_level got=%0h want=80", bus.envelopeLevel); end
        // Gate stays high while in sustain; outputs go through the scoreboard.
        for (int i = 0; i < 100; i++) begin
            v = 8'($urandom_range(0, 255));
            bus.inputSample = v;
            sb.push_back('{v, model_out(v, 8'h80)});
            tick();
            e = sb.pop_front();
            total++;
            if (bus.outputSample !== e.value) begin
                bad++;
                $display("FAIL sustain_out in=%0d got=%0d want=%0d", e.sample, bus.outputSample, e.value);
            end else begin
                $display("sustain txn in=%0d out=%0d", e.sample, bus.outputSample);
            end
        end
        bus.noteOn = 1'b0;
        tick();
        total++; if (bus.envelopeState !== S_RELEASE) begin bad++; $display("FAIL release_entry got=%0d want=%0d", bus.envelopeState, S_RELEASE); end
        n = 1;
        while (n < 2000) begin
            tick();
            if (bus.envelopeState !== S_RELEASE) break;
            n++;
        end
        total++; if (n != 512) begin bad++; $display("FAIL release_len got=%0d want=512", n); end
        total++; if (bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL release_end_state got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL release_end_busy got=%b want=0", bus.busy); end
        total++; if (bus.envelopeLevel !== 8'h00) begin bad++; $display("FAIL release_end_level got=%0h want=00", bus.envelopeLevel); end
    endtask

    task automatic test_scaling();
        int  n;
        bit  ok;
        exp_t e;
        logic [7:0] tbl_a [8] = '{8'd200, 8'd255, 8'd0, 8'd1, 8'd127, 8'd128, 8'd129, 8'd77};
        logic [7:0] tbl_b [4] = '{8'd0, 8'd255, 8'd64, 8'd130};
        bus.attackStep   = 8'd0;
        bus.decayStep    = 8'd0;
        bus.releaseStep  = 8'd0;
        bus.sustainLevel = 8'h80;
        bus.noteOn       = 1'b1;
        wait_for_state(S_SUSTAIN, 10, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL scale_reach_sustain got=%0d want=%0d", bus.envelopeState, S_SUSTAIN); end
        foreach (tbl_a[i]) begin
            bus.inputSample = tbl_a[i];
            sb.push_back('{tbl_a[i], model_out(tbl_a[i], 8'h80)});
            tick();
            e = sb.pop_front();
            total++;
            if (bus.outputSample !== e.value) begin bad++; $display("FAIL scale80 in=%0d got=%0d want=%0d", e.sample, bus.outputSample, e.value); end
            else $display("scale80 txn in=%0d out=%0d", e.sample, bus.outputSample);
        end
        // Sustain follows live changes; full level passes the sample unchanged.
        bus.sustainLevel = 8'hFF;
        tick();
        total++; if (bus.envelopeLevel !== 8'hFF) begin bad++; $display("FAIL sustain_follow_ff got=%0h want=ff", bus.envelopeLevel); end
        foreach (tbl_a[i]) begin
            bus.inputSample = tbl_a[i];
            sb.push_back('{tbl_a[i], tbl_a[i]});
            tick();
            e = sb.pop_front();
            total++;
            if (bus.outputSample !== e.value) begin bad++; $display("FAIL scaleff in=%0d got=%0d want=%0d", e.sample, bus.outputSample, e.value); end
            else $display("scaleff txn in=%0d out=%0d", e.sample, bus.outputSample);
        end
        bus.sustainLevel = 8'h7F;
        tick();
        total++; if (bus.envelopeLevel !== 8'h7F) begin bad++; $display("FAIL sustain_follow_7f got=%0h want=7f", bus.envelopeLevel); end
        foreach (tbl_b[i]) begin
            bus.inputSample = tbl_b[i];
            sb.push_back('{tbl_b[i], model_out(tbl_b[i], 8'h7F)});
            tick();
            e = sb.pop_front();
            total++;
            if (bus.outputSample !== e.value) begin bad++; $display("FAIL scale7f in=%0d got=%0d want=%0d", e.sample, bus.outputSample, e.value); end
            else $display("scale7f txn in=%0d out=%0d", e.sample, bus.outputSample);
        end
        bus.noteOn = 1'b0;
        wait_for_state(S_IDLE, 10, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL scale_back_idle got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        bus.inputSample = 8'd200;
        sb.push_back('{8'd200, IDLE_OUT});
        tick();
        e = sb.pop_front();
        total++;
        if (bus.outputSample !== e.value) begin bad++; $display("FAIL idle_out in=%0d got=%0d want=%0d", e.sample, bus.outputSample, e.value); end
        else $display("idle txn in=%0d out=%0d", e.sample, bus.outputSample);
    endtask

    task automatic test_zero_steps();
        bus.attackStep   = 8'd0;
        bus.decayStep    = 8'd0;
        bus.releaseStep  = 8'd0;
        bus.sustainLevel = 8'h40;
        bus.noteOn       = 1'b1;
        tick();
        total++; if (bus.envelopeState !== S_ATTACK || bus.envelopeLevel !== 8'h00) begin bad++; $display("FAIL zero_rise got=%0d/%0h want=%0d/00", bus.envelopeState, bus.envelopeLevel, S_ATTACK); end
        tick();
        total++; if (bus.envelopeState !== S_DECAY || bus.envelopeLevel !== 8'hFF) begin bad++; $display("FAIL zero_attack got=%0d/%0h want=%0d/ff", bus.envelopeState, bus.envelopeLevel, S_DECAY); end
        tick();
        total++; if (bus.envelopeState !== S_SUSTAIN || bus.envelopeLevel !== 8'h40) begin bad++; $display("FAIL zero_decay got=%0d/%0h want=%0d/40", bus.envelopeState, bus.envelopeLevel, S_SUSTAIN); end
        bus.noteOn = 1'b0;
        tick();
        total++; if (bus.envelopeState !== S_RELEASE || bus.envelopeLevel !== 8'h40) begin bad++; $display("FAIL zero_fall got=%0d/%0h want=%0d/40", bus.envelopeState, bus.envelopeLevel, S_RELEASE); end
        tick();
        total++; if (bus.envelopeState !== S_IDLE || bus.envelopeLevel !== 8'h00 || bus.busy !== 1'b0) begin bad++; $display("FAIL zero_release got=%0d/%0h/%b want=%0d/00/0", bus.envelopeState, bus.envelopeLevel, bus.busy, S_IDLE); end
    endtask

    task automatic test_back_to_back();
        bus.noteOn = 1'b1;
        repeat (3) tick();
        bus.noteOn = 1'b0;
        tick();
        total++; if (bus.envelopeState !== S_RELEASE) begin bad++; $display("FAIL b2b_release got=%0d want=%0d", bus.envelopeState, S_RELEASE); end
        // Rise on the very tick release would reach zero: attack wins.
        bus.noteOn = 1'b1;
        tick();
        total++; if (bus.envelopeState !== S_ATTACK || bus.envelopeLevel !== 8'h00) begin bad++; $display("FAIL b2b_retrigger got=%0d/%0h want=%0d/00", bus.envelopeState, bus.envelopeLevel, S_ATTACK); end
        tick();
        total++; if (bus.envelopeState !== S_DECAY || bus.envelopeLevel !== 8'hFF) begin bad++; $display("FAIL b2b_attack got=%0d/%0h want=%0d/ff", bus.envelopeState, bus.envelopeLevel, S_DECAY); end
        // Fall in decay: the decay rule still applies on that edge.
        bus.noteOn = 1'b0;
        tick();
        total++; if (bus.envelopeState !== S_RELEASE || bus.envelopeLevel !== 8'h40) begin bad++; $display("FAIL b2b_decay_fall got=%0d/%0h want=%0d/40", bus.envelopeState, bus.envelopeLevel, S_RELEASE); end
        tick();
        total++; if (bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL b2b_idle got=%0d want=%0d", bus.envelopeState, S_IDLE); end
    endtask

    task automatic test_retrigger();
        int  n;
        bit  ok;
        logic [7:0] min_level;
        bus.attackStep   = 8'd16;
        bus.decayStep    = 8'd255;
        bus.sustainLevel = 8'hC0;
        bus.releaseStep  = 8'd1;
        bus.noteOn       = 1'b1;
        wait_for_state(S_SUSTAIN, 6000, n, ok);
        total++; if (!ok || bus.envelopeLevel !== 8'hC0) begin bad++; $display("FAIL retrig_sustain got=%0h want=c0 (reached=%0b)", bus.envelopeLevel, ok); end
        bus.noteOn = 1'b0;
        tick();
        total++; if (bus.envelopeState !== S_RELEASE) begin bad++; $display("FAIL retrig_release got=%0d want=%0d", bus.envelopeState, S_RELEASE); end
        min_level = bus.envelopeLevel;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.envelopeLevel < min_level) min_level = bus.envelopeLevel;
        end
        bus.noteOn = 1'b1;
        tick();
        if (bus.envelopeLevel < min_level) min_level = bus.envelopeLevel;
        // acc = C000 - 10 = BFF6 here.
        total++; if (bus.envelopeState !== S_ATTACK || bus.envelopeLevel !== 8'hBF) begin bad++; $display("FAIL retrig_resume got=%0d/%0h want=%0d/bf", bus.envelopeState, bus.envelopeLevel, S_ATTACK); end
        tick();
        if (bus.envelopeLevel < min_level) min_level = bus.envelopeLevel;
        // BFF6 + 16 = C006.
        total++; if (bus.envelopeState !== S_ATTACK || bus.envelopeLevel !== 8'hC0) begin bad++; $display("FAIL retrig_step got=%0d/%0h want=%0d/c0", bus.envelopeState, bus.envelopeLevel, S_ATTACK); end
        total++; if (min_level !== 8'hBF) begin bad++; $display("FAIL retrig_min_level got=%0h want=bf", min_level); end
    endtask

    task automatic test_reset_mid_note();
        int  n;
        bit  ok;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL midreset_state got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        total++; if (bus.envelopeLevel !== 8'h00) begin bad++; $display("FAIL midreset_level got=%0h want=00", bus.envelopeLevel); end
        total++; if (bus.outputSample !== IDLE_OUT) begin bad++; $display("FAIL midreset_out got=%0d want=%0d", bus.outputSample, IDLE_OUT); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
        bus.noteOn = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_for_state(S_ATTACK, 4, n, ok);
        total++; if (ok || bus.envelopeState !== S_IDLE) begin bad++; $display("FAIL midreset_no_tail got=%0d want=%0d", bus.envelopeState, S_IDLE); end
        $display("midreset: state=%0d level=%0h out=%0d", bus.envelopeState, bus.envelopeLevel, bus.outputSample);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.noteOn       = 1'b0;
        bus.inputSample  = 8'd0;
        bus.attackStep   = 8'd0;
        bus.decayStep    = 8'd0;
        bus.sustainLevel = 8'd0;
        bus.releaseStep  = 8'd0;
        test_reset();
        test_full_adsr();
        test_scaling();
        test_zero_steps();
        test_back_to_back();
        test_retrigger();
        test_reset_mid_note();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
